// File: rtl/cart_pkg.sv
// Shared types for the cart ROM fetch path: FSM encoding,
// SDRAM word address and cache line layout.
package cart_pkg;

  localparam int CART_ADDR_W = 19;
  localparam int WORD_W = CART_ADDR_W - 1;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t IDLE = 2'd0;
  localparam fetch_state_t RD   = 2'd1;
  localparam fetch_state_t PF   = 2'd2;
  localparam fetch_state_t WR   = 2'd3;

  typedef logic [WORD_W-1:0] word_addr_t;

  typedef struct packed {
    logic       valid;
    word_addr_t tag;
    logic [15:0] data;
  } line_t;

  function automatic logic [7:0] sel_byte(
    input logic [15:0] w,
    input logic        odd
  );
    return odd ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/cart_rom_fetch_if.sv
// 16-bit SDRAM request port: req held until a 1-cycle ack,
// read data valid in the ack cycle.
interface cart_rom_fetch_if
  import cart_pkg::*;
#(
  parameter int ADDR_W = CART_ADDR_W
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-2:0] mem_addr;
  logic [1:0]        mem_be;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/cart_dl_packer.sv
// Packs the ROM download byte stream into 16-bit SDRAM writes,
// holding the loader off with dl_wait while a write is pending.
module cart_dl_packer
  import cart_pkg::*;
#(
  parameter int ADDR_W = CART_ADDR_W
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              wr_done,
  output logic              wr_req,
  output word_addr_t        wr_addr,
  output logic [15:0]       wr_data,
  output logic [1:0]        wr_be,
  output logic              dl_wait
);

  logic       buf_valid;
  word_addr_t buf_addr;
  logic [7:0] buf_data;
  logic       act_q;

  word_addr_t dl_word;
  logic       even_wr;
  logic       odd_wr;
  logic       flush;
  logic       pair;

  assign dl_word = dl_addr[ADDR_W-1:1];
  assign even_wr = dl_active & dl_wr & ~dl_addr[0];
  assign odd_wr  = dl_active & dl_wr & dl_addr[0];
  assign flush   = act_q & ~dl_active & buf_valid;
  assign pair    = buf_valid & (buf_addr == dl_word);
  assign dl_wait = wr_req;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      act_q     <= 1'b0;
      wr_req    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_be     <= '0;
    end else begin
      act_q <= dl_active;
      if (wr_done) begin
        wr_req <= 1'b0;
      end
      unique case (1'b1)
        even_wr: begin
          buf_valid <= 1'b1;
          buf_addr  <= dl_word;
          buf_data  <= dl_data;
        end
        odd_wr: begin
          // A lone odd byte only owns the high lane.
          wr_req    <= 1'b1;
          wr_addr   <= dl_word;
          buf_valid <= 1'b0;
          if (pair) begin
            wr_data <= {dl_data, buf_data};
            wr_be   <= 2'b11;
          end else begin
            wr_data <= {dl_data, 8'h00};
            wr_be   <= 2'b10;
          end
        end
        flush: begin
          wr_req    <= 1'b1;
          wr_addr   <= buf_addr;
          wr_data   <= {8'h00, buf_data};
          wr_be     <= 2'b01;
          buf_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cart_rom_fetch.sv
// Mapper ROM port: two-line word cache (primary + sequential
// prefetch) in front of SDRAM, plus the download write path.
module cart_rom_fetch
  import cart_pkg::*;
#(
  parameter int ADDR_W   = CART_ADDR_W,
  parameter bit PREFETCH = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              rom_rd,
  input  logic [ADDR_W-1:0] rom_address,
  output logic [7:0]        rom_din,
  output logic              rom_valid,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_wait,
  cart_rom_fetch_if.master  mem
);

  fetch_state_t state;
  line_t        prim;
  line_t        pfl;
  logic         need_pf;
  logic         drop_fill;
  logic         dl_q;

  word_addr_t   word;
  word_addr_t   fill_tag;
  logic         rd_en;
  logic         hit_p;
  logic         hit_f;
  logic         miss;
  logic         dl_rise;
  logic         fill_ok;
  logic         fwd;

  logic         wr_req;
  logic         wr_done;
  word_addr_t   wr_addr;
  logic [15:0]  wr_data;
  logic [1:0]   wr_be;

  assign word     = rom_address[ADDR_W-1:1];
  assign rd_en    = rom_rd & ~dl_active;
  assign hit_p    = rd_en & prim.valid & (prim.tag == word);
  assign hit_f    = rd_en & pfl.valid & (pfl.tag == word);
  assign miss     = rd_en & ~hit_p & ~hit_f;
  assign dl_rise  = dl_active & ~dl_q;
  assign wr_done  = (state == WR) & mem.mem_ack;
  assign fill_tag = mem.mem_addr;

  // Fetches that straddle a download start carry stale data.
  assign fill_ok  = mem.mem_ack & ~drop_fill & ~dl_active;
  assign fwd      = rd_en & fill_ok & (fill_tag == word)
                  & ((state == RD) | (state == PF));

  cart_dl_packer #(
    .ADDR_W (ADDR_W)
  ) u_packer (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .wr_done   (wr_done),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .dl_wait   (dl_wait)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      prim          <= '0;
      pfl           <= '0;
      need_pf       <= 1'b0;
      drop_fill     <= 1'b0;
      dl_q          <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
    end else begin
      dl_q <= dl_active;
      unique case (state)
        IDLE: begin
          drop_fill <= 1'b0;
          if (wr_req) begin
            state         <= WR;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= wr_addr;
            mem.mem_be    <= wr_be;
            mem.mem_wdata <= wr_data;
          end else if (miss) begin
            state         <= RD;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= word;
            mem.mem_be    <= 2'b11;
            mem.mem_wdata <= '0;
          end else if (need_pf && PREFETCH) begin
            state         <= PF;
            need_pf       <= 1'b0;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= prim.tag + word_addr_t'(1);
            mem.mem_be    <= 2'b11;
            mem.mem_wdata <= '0;
          end else if (hit_f && !hit_p) begin
            prim      <= pfl;
            pfl.valid <= 1'b0;
            need_pf   <= PREFETCH;
          end
        end
        RD: begin
          if (mem.mem_ack) begin
            state       <= IDLE;
            mem.mem_req <= 1'b0;
            need_pf     <= PREFETCH && fill_ok;
            if (fill_ok) begin
              prim <= '{valid: 1'b1, tag: fill_tag,
                         data: mem.mem_rdata};
            end
          end
        end
        PF: begin
          if (mem.mem_ack) begin
            state       <= IDLE;
            mem.mem_req <= 1'b0;
            if (fill_ok) begin
              pfl <= '{valid: 1'b1, tag: fill_tag,
                        data: mem.mem_rdata};
            end
          end
        end
        WR: begin
          if (mem.mem_ack) begin
            state       <= IDLE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (dl_rise) begin
        prim.valid <= 1'b0;
        pfl.valid  <= 1'b0;
        need_pf    <= 1'b0;
        drop_fill  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_valid <= 1'b0;
      rom_din   <= '0;
    end else begin
      rom_valid <= 1'b0;
      if (fwd) begin
        rom_valid <= 1'b1;
        rom_din   <= sel_byte(mem.mem_rdata, rom_address[0]);
      end else if (hit_p) begin
        rom_valid <= 1'b1;
        rom_din   <= sel_byte(prim.data, rom_address[0]);
      end else if (hit_f) begin
        rom_valid <= 1'b1;
        rom_din   <= sel_byte(pfl.data, rom_address[0]);
      end
    end
  end

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Directed bench for cart_rom_fetch with a small SDRAM model
// that logs every completed request.
module tb_cart_rom_fetch;

  typedef struct packed {
    logic        we;
    logic [1:0]  be;
    logic [17:0] addr;
    logic [15:0] wd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rom_rd;
  logic [18:0] rom_address;
  logic [7:0]  rom_din;
  logic        rom_valid;
  logic        dl_active;
  logic        dl_wr;
  logic [18:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;

  logic        model_ack;
  logic        manual_ack;
  logic [15:0] model_rdata;
  logic        loaded;
  int          cnt;
  int          ack_dly;
  logic [15:0] sdram [0:16383];
  ent_t        trace [$];

  int total;
  int passed;
  int base;
  logic seen;

  cart_rom_fetch_if #(.ADDR_W(19)) bus ();

  assign bus.mem_ack   = model_ack | manual_ack;
  assign bus.mem_rdata = manual_ack ? 16'hDEAD : model_rdata;

  cart_rom_fetch #(
    .ADDR_W   (19),
    .PREFETCH (1'b1)
  ) dut (
    .clk_sys     (clk),
    .reset_n     (rst_n),
    .rom_rd      (rom_rd),
    .rom_address (rom_address),
    .rom_din     (rom_din),
    .rom_valid   (rom_valid),
    .dl_active   (dl_active),
    .dl_wr       (dl_wr),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .dl_wait     (dl_wait),
    .mem         (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    model_ack <= 1'b0;
    if (!rst_n) begin
      cnt <= 0;
      if (!loaded) begin
        for (int i = 0; i < 16384; i++) sdram[i] <= 16'h0000;
        sdram[14'h0008] <= 16'hBBAA;
        sdram[14'h0009] <= 16'hDDCC;
        sdram[14'h0080] <= 16'h1234;
        sdram[14'h0100] <= 16'h7766;
        sdram[14'h2000] <= 16'h3344;
        loaded <= 1'b1;
      end
    end else if (bus.mem_req && !model_ack) begin
      if (cnt >= ack_dly) begin
        cnt         <= 0;
        model_ack   <= 1'b1;
        model_rdata <= sdram[bus.mem_addr[13:0]];
        if (bus.mem_we) begin
          sdram[bus.mem_addr[13:0]] <= {
            bus.mem_be[1] ? bus.mem_wdata[15:8]
                          : sdram[bus.mem_addr[13:0]][15:8],
            bus.mem_be[0] ? bus.mem_wdata[7:0]
                          : sdram[bus.mem_addr[13:0]][7:0]};
        end
        trace.push_back('{we: bus.mem_we, be: bus.mem_be,
                          addr: bus.mem_addr, wd: bus.mem_wdata});
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int count_rd(input int from, input logic [17:0] a);
    int n = 0;
    for (int i = from; i < trace.size(); i++)
      if (!trace[i].we && trace[i].addr == a) n++;
    return n;
  endfunction

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rom_valid) break;
    end
    check(tag, rom_valid, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int low = 0;
    for (int i = 0; i < 200 && low < 4; i++) begin
      @(negedge clk);
      low = bus.mem_req ? 0 : low + 1;
    end
    check(tag, bus.mem_req, 1'b0);
  endtask

  task automatic wait_dl_low(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (!dl_wait) break;
      @(negedge clk);
    end
    check(tag, dl_wait, 1'b0);
  endtask

  task automatic dl_byte(input logic [18:0] a, input logic [7:0] d);
    wait_dl_low("dl_ready");
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    @(negedge clk);
    dl_wr   = 1'b0;
  endtask

  task automatic invalidate();
    dl_active = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dl_active = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    total = 0; passed = 0; loaded = 1'b0;
    rst_n = 1'b0; rom_rd = 1'b0; rom_address = '0;
    dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    manual_ack = 1'b0; ack_dly = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", rom_valid, 1'b0);
    check("rst_din", rom_din, 8'h00);
    check("rst_dl_wait", dl_wait, 1'b0);
    check("rst_req", bus.mem_req, 1'b0);
    check("rst_we", bus.mem_we, 1'b0);
    check("rst_addr", bus.mem_addr, 18'h0);
    check("rst_be", bus.mem_be, 2'b00);
    check("rst_wdata", bus.mem_wdata, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: miss then same-word hit
    base = trace.size();
    rom_rd = 1'b1; rom_address = 19'h00010;
    wait_valid("t1_valid_aa");
    check("t1_din_aa", rom_din, 8'hAA);
    rom_address = 19'h00011;
    @(negedge clk);
    check("t1_valid_bb", rom_valid, 1'b1);
    check("t1_din_bb", rom_din, 8'hBB);
    wait_idle("t1_idle");
    check("t1_first_addr", trace[base].addr, 18'h8);
    check("t1_reqs_w8", count_rd(base, 18'h8), 1);

    // 2: prefetch of word+1 and 1-cycle hit on it
    rom_rd = 1'b0;
    invalidate();
    base = trace.size();
    rom_rd = 1'b1; rom_address = 19'h00010;
    wait_valid("t2_valid_aa");
    check("t2_din_aa", rom_din, 8'hAA);
    for (int i = 0; i < 60 && trace.size() < base + 2; i++)
      @(negedge clk);
    check("t2_pf_addr", trace[base+1].addr, 18'h9);
    check("t2_pf_we", trace[base+1].we, 1'b0);
    rom_address = 19'h00012;
    @(negedge clk);
    check("t2_valid_cc", rom_valid, 1'b1);
    check("t2_din_cc", rom_din, 8'hCC);
    wait_idle("t2_idle");
    check("t2_reqs_w9", count_rd(base, 18'h9), 1);

    // 3: download packing and final flush
    rom_rd = 1'b0;
    base = trace.size();
    dl_active = 1'b1;
    @(negedge clk);
    dl_byte(19'h0, 8'h11);
    dl_byte(19'h1, 8'h22);
    check("t3_wait_pair", dl_wait, 1'b1);
    dl_byte(19'h2, 8'h33);
    dl_active = 1'b0;
    @(negedge clk);
    check("t3_wait_flush", dl_wait, 1'b1);
    wait_dl_low("t3_flush_done");
    wait_idle("t3_idle");
    check("t3_nwr", trace.size() - base, 2);
    check("t3_w0", {trace[base].we, trace[base].be,
                    trace[base].addr, trace[base].wd},
          {1'b1, 2'b11, 18'h0, 16'h2211});
    check("t3_w1", {trace[base+1].we, trace[base+1].be,
                    trace[base+1].addr, trace[base+1].wd[7:0]},
          {1'b1, 2'b01, 18'h1, 8'h33});

    // 4: address moves while a slow read is outstanding
    ack_dly = 6;
    base = trace.size();
    seen = 1'b0;
    rom_rd = 1'b1; rom_address = 19'h00100;
    @(negedge clk);
    @(negedge clk);
    rom_address = 19'h04000;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (count_rd(base, 18'h2000) != 0) break;
      if (rom_valid) seen = 1'b1;
    end
    check("t4_no_valid", seen, 1'b0);
    check("t4_first", trace[base].addr, 18'h80);
    check("t4_second", trace[base+1].addr, 18'h2000);
    wait_valid("t4_valid");
    check("t4_din", rom_din, 8'h44);
    ack_dly = 1;
    wait_idle("t4_idle");

    // 5: reset with a request outstanding, then a stray ack
    ack_dly = 20;
    rom_address = 19'h00200;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t5_req_up", bus.mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_req_async", bus.mem_req, 1'b0);
    check("t5_valid_rst", rom_valid, 1'b0);
    rom_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    check("t5_stray_req", bus.mem_req, 1'b0);
    check("t5_stray_valid", rom_valid, 1'b0);
    ack_dly = 1;
    rom_rd = 1'b1; rom_address = 19'h00000;
    @(negedge clk);
    check("t5_miss_req", bus.mem_req, 1'b1);
    check("t5_miss_addr", bus.mem_addr, 18'h0);
    wait_valid("t5_valid");
    check("t5_din", rom_din, 8'h11);
    wait_idle("t5_idle");

    // 6: download rewrites a cached word
    rom_address = 19'h00200;
    wait_valid("t6_valid_old");
    check("t6_din_old", rom_din, 8'h66);
    rom_address = 19'h00201;
    @(negedge clk);
    check("t6_din_old_hi", rom_din, 8'h77);
    wait_idle("t6_idle");
    rom_rd = 1'b0;
    dl_active = 1'b1;
    @(negedge clk);
    dl_byte(19'h00200, 8'h5A);
    dl_byte(19'h00201, 8'hA5);
    wait_dl_low("t6_dl_done");
    dl_active = 1'b0;
    @(negedge clk);
    base = trace.size();
    rom_rd = 1'b1; rom_address = 19'h00200;
    @(negedge clk);
    check("t6_miss", rom_valid, 1'b0);
    wait_valid("t6_valid_new");
    check("t6_din_new", rom_din, 8'h5A);
    check("t6_refetch", count_rd(base, 18'h100), 1);
    rom_address = 19'h00201;
    @(negedge clk);
    check("t6_din_new_hi", rom_din, 8'hA5);
    rom_rd = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
